// File: rtl/morse_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared constants for the morse decoder back end: letter width, UART state
// encoding and frame length.
// Configuration macro: TX_PARITY_EN. When it is defined, frames carry an even
// parity bit (8E1) and the PARITY state exists. Otherwise frames are 8N1.
// -----------------------------------------------------------------------------
package morse_pkg;

  // Character width produced by the morse FSM.
  localparam int LETTER_W = 8;

  // UART transmitter state encoding. The encodings are kept as plain constants
  // so they match the legacy decoder code.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // Line bits per frame: start + 8 data + [parity] + stop.
`ifdef TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  // Even parity over one letter. A '1' here makes the total count of ones even.
  function automatic logic even_parity(input logic [LETTER_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/morse_uart_tx_if.sv
// -----------------------------------------------------------------------------
// morse_uart_tx_if
// Bundles the signals between the morse FSM, the UART back end and the status
// observers.
//   letter, done, clear_ovf : morse FSM side -> transmitter
//   tx, busy, empty, full, count, overflow : transmitter -> line / status
// Modports:
//   master : the side that produces letters and observes the status
//   slave  : the morse_uart_tx block
// -----------------------------------------------------------------------------
interface morse_uart_tx_if #(
  parameter int DEPTH_LOG2 = 4
);
  import morse_pkg::*;

  logic [LETTER_W-1:0] letter;
  logic                done;
  logic                clear_ovf;
  logic                tx;
  logic                busy;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;

  modport master (
    output letter, done, clear_ovf,
    input  tx, busy, empty, full, count, overflow
  );

  modport slave (
    input  letter, done, clear_ovf,
    output tx, busy, empty, full, count, overflow
  );

endinterface

// File: rtl/morse_uart_tx_letter_fifo.sv
// -----------------------------------------------------------------------------
// letter_fifo
// Letter queue with first-word-fall-through output. Storage is a register
// array; full and empty are derived from the occupancy count.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   push, din  : write request and data
//   pop        : read request (ignored when empty)
//   dout       : head entry, valid whenever empty is low
//   count      : occupancy 0..2**DEPTH_LOG2
//   full/empty : occupancy flags
//   drop       : push refused because the queue was full with no pop
// -----------------------------------------------------------------------------
module letter_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [LETTER_W-1:0] din,
  output logic [LETTER_W-1:0] dout,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty,
  output logic                drop
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [LETTER_W-1:0]   r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_wr_en;
  logic                  w_rd_en;

  assign full  = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty = (r_count == '0);

  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign w_rd_en = pop & ~empty;
  assign w_wr_en = push & (~full | w_rd_en);
  assign drop    = push & ~w_wr_en;

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

  // NOTE: storage has no reset; entries are only read after being written,
  // so clearing the array would add logic without changing behaviour.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= din;
  end

  // Pointers are exactly DEPTH_LOG2 bits wide, so they wrap modulo depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/morse_uart_tx.sv
// -----------------------------------------------------------------------------
// morse_uart_tx
// Queues letters completed by the morse decoder and sends them out a UART TX
// line, LSB first, one start bit and one stop bit.
// Configuration macro: TX_PARITY_EN adds an even parity bit (8E1 frames).
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous, active-high reset
//   bus   : morse_uart_tx_if.slave
//           letter/done   - character and its completion strobe or level
//           clear_ovf     - synchronous clear of the overflow flag
//           tx            - serial out, idle high, driven from a register
//           busy          - a frame is on the line
//           empty/full/count - queue status
//           overflow      - sticky, a letter was dropped
// -----------------------------------------------------------------------------
module morse_uart_tx
  import morse_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DEPTH_LOG2   = 4
) (
  input logic           clk,
  input logic           reset,
  morse_uart_tx_if.slave bus
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic                r_done_q;
  logic                r_overflow;
  logic [2:0]          r_state;
  logic [LETTER_W-1:0] r_shift;
  logic [2:0]          r_bit_cnt;
  logic [BAUD_W-1:0]   r_baud_cnt;
  logic                r_tx;
`ifdef TX_PARITY_EN
  logic                r_parity;
`endif

  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_full;
  logic                w_empty;
  logic                w_bit_end;
  logic [LETTER_W-1:0] w_head;
  logic [DEPTH_LOG2:0] w_count;

  // A held-high done writes only once: only its rising edge pushes.
  assign w_push    = bus.done & ~r_done_q;
  assign w_pop     = (r_state == S_IDLE) & ~w_empty;
  assign w_bit_end = (r_baud_cnt == BAUD_LAST);

  letter_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (w_push),
    .pop  (w_pop),
    .din  (bus.letter),
    .dout (w_head),
    .count(w_count),
    .full (w_full),
    .empty(w_empty),
    .drop (w_drop)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done_q   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done_q <= bus.done;
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop)             r_overflow <= 1'b1;
      else if (bus.clear_ovf) r_overflow <= 1'b0;
    end
  end

  // Transmit state machine. r_tx is loaded with the level of the state being
  // entered, so the line changes exactly at the bit boundary edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
      r_tx       <= 1'b1;
`ifdef TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      if (r_state != S_IDLE) begin
        r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + BAUD_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_shift    <= w_head;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b0;
            r_state    <= S_START;
`ifdef TX_PARITY_EN
            r_parity   <= even_parity(w_head);
`endif
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == 3'd7) begin
`ifdef TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= {1'b0, r_shift[LETTER_W-1:1]};
              r_tx      <= r_shift[1];
            end
          end
        end

`ifdef TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx       = r_tx;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.count    = w_count;
  assign bus.overflow = r_overflow;

endmodule

// File: doc/morse_uart_tx.md
Name: morse_uart_tx

Overview:
- Downstream consumer of the morse decoder FSM's letter/done outputs.
- Captures each decoded 8-bit letter into a small FIFO, then serialises it out an 8N1 UART TX line (optionally 8E1) for host display.
- Decouples bursty letter completion from fixed-rate serial output; reports overflow when the operator outpaces the line.

Parameters:
- CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600 baud); legal range 4..65535.
- DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries (default 16); legal range 1..8.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- letter  input  8  decoded character from the morse FSM; valid when done rises.
- done  input  1  letter-complete from the morse FSM; may be a pulse or a held level.
- clear_ovf  input  1  synchronous clear of the overflow flag.
- tx  output  1  UART serial out, idle high.
- busy  output  1  high while a frame is on the line (state != IDLE).
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds 2**DEPTH_LOG2 entries.
- count  output  DEPTH_LOG2+1  current FIFO occupancy.
- overflow  output  1  sticky; a letter was dropped because the FIFO was full.

Behaviour:
- Reset values, applied asynchronously: tx=1, busy=0, empty=1, full=0, count=0, overflow=0; FIFO pointers 0; state IDLE; done_q=0.
- Capture:
  - done_q registers done.
  - push = done & ~done_q, so a held-high done writes exactly once; letter is sampled on that same edge.
- Push acceptance: push is accepted if count < depth, or if a pop occurs in the same cycle.
  - Otherwise the letter is dropped and overflow sets on that edge.
- overflow: clear_ovf clears it on the next edge; a drop in the same cycle as clear_ovf wins, and overflow stays 1.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pointers wrap modulo depth; full and empty derive from count.
- UART state machine, states IDLE, START, DATA, [PARITY], STOP:
  - IDLE: tx=1. If !empty: pop, load shift register with the head entry, clear bit counter and baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7 go to PARITY if enabled, else STOP.
  - PARITY: tx = ^data (even parity) for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- Back-to-back frames: IDLE lasts exactly one cycle between frames when the FIFO is non-empty.
- Latency:
  - Edge E samples done=1, done_q=0; the entry is written at E.
  - empty falls after E.
  - State leaves IDLE at E+1, and tx falls after E+1 (if the UART was idle).
- Frame length: 10*CLKS_PER_BIT cycles, or 11* with parity, plus 1 IDLE cycle.
- Baud counter: width = clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps.
- Reset mid-frame: tx returns high immediately and all queued letters are discarded.
- No filtering: any letter value, including 8'h00, is queued and sent as-is.
- tx is driven from a register (no glitches).

Optional Feature:
- Macro TX_PARITY_EN.
- Defined: PARITY state included; 8E1 frames of 11 bits; parity bit = XOR of the 8 data bits.
- Undefined: PARITY state absent (not merely unreachable); 8N1 frames of 10 bits.

Decomposition:
- Package morse_pkg:
  - UART state enum (IDLE, START, DATA, PARITY, STOP).
  - LETTER_W=8 shared with the morse FSM.
  - FRAME_BITS constant chosen by TX_PARITY_EN.
- Sub-module letter_fifo:
  - Parameter DEPTH_LOG2.
  - Ports push, pop, din, dout, count, full, empty, drop.
  - Register-array storage, first-word-fall-through output.
- The top instantiates letter_fifo plus the edge detect, overflow flag and UART state machine.

Test Plan:
- Single letter (CLKS_PER_BIT=4): reset, then one-cycle pulse done with letter=8'h53 'S'.
  - tx falls 2 edges later.
  - Sampled mid-bit: 0,1,1,0,0,1,0,1,0,1 (start, LSB-first data, stop).
  - busy high for exactly 40 cycles; empty=1 afterwards.
- Held done: done held high 50 cycles, letter=8'h45.
  - Exactly one frame is sent; count peaks at 1.
- Burst/overflow (DEPTH_LOG2=2, UART stalled behind a first frame):
  - Push 'A','B','C','D','E','F' while the first frame is sending.
  - count=4, full=1, overflow=1; a later clear_ovf clears the flag.
  - Output order: A,B,C,D,E; F is lost.
- Simultaneous push/pop when full: push lands on the IDLE pop cycle.
  - Accepted; count stays 4; overflow stays 0.
- Reset mid-frame: reset asserted during DATA bit 3 with 2 entries queued.
  - tx=1 and busy=0 combinationally; count=0.
  - No further frames after reset releases.
- TX_PARITY_EN defined, letter=8'h07:
  - Parity bit = 1; frame is 11 bits; busy lasts 44 cycles at CLKS_PER_BIT=4.
